// File: rtl/scp_mem_watch.sv
// Data-memory watch unit: snoops processor writes against NUM_CH watch addresses
// and logs qualifying writes with a timestamp into a show-ahead event FIFO.
module scp_mem_watch #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 32,
    parameter int DEPTH  = 8,
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int CNT_FW = $clog2(DEPTH) + 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enable,
    input  logic                     mode,
    input  logic [NUM_CH-1:0]        watch_en,
    input  logic [NUM_CH*ADDR_W-1:0] watch_addr,
    input  logic                     mem_we,
    input  logic [ADDR_W-1:0]        mem_addr,
    input  logic [DATA_W-1:0]        mem_wdata,
    output logic                     evt_valid,
    input  logic                     evt_ready,
    output logic [CH_W-1:0]          evt_ch,
    output logic [DATA_W-1:0]        evt_data,
    output logic [CNT_W-1:0]         evt_cycle,
    output logic [CNT_FW-1:0]        fifo_count,
    output logic [CNT_W-1:0]         cycle,
    output logic                     overflow,
    output logic [15:0]              drop_count,
    input  logic                     ovf_clr
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [CNT_W-1:0]  r_cycle;
    logic [DATA_W-1:0] r_shadow [NUM_CH];
    logic [NUM_CH-1:0] w_hit;
    logic [NUM_CH-1:0] w_qual;
    logic              w_any;
    logic [CH_W-1:0]   w_sel;

    logic [CH_W-1:0]   r_fch   [DEPTH];
    logic [DATA_W-1:0] r_fdata [DEPTH];
    logic [CNT_W-1:0]  r_fcyc  [DEPTH];
    logic [PTR_W-1:0]  r_rd;
    logic [PTR_W-1:0]  r_wr;
    logic [CNT_FW-1:0] r_count;
    logic              r_overflow;
    logic [15:0]       r_drop;

    logic w_empty;
    logic w_full;
    logic w_pop;
    logic w_push;
    logic w_drop;

    always_comb begin
        w_hit  = '0;
        w_qual = '0;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            w_hit[c]  = mem_we & enable & watch_en[c] &
                        (mem_addr == watch_addr[c*ADDR_W +: ADDR_W]);
            w_qual[c] = w_hit[c] & (~mode | (mem_wdata != r_shadow[c]));
        end
    end

    // Descending scan so the lowest qualifying channel is the one that sticks.
    always_comb begin
        w_sel = '0;
        for (int unsigned c = NUM_CH; c > 0; c--) begin
            if (w_qual[c-1]) w_sel = CH_W'(c - 1);
        end
    end

    assign w_any   = |w_qual;
    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == CNT_FW'(DEPTH));
    assign w_pop   = ~w_empty & evt_ready;
    assign w_push  = w_any & (~w_full | w_pop);
    assign w_drop  = w_any & w_full & ~w_pop;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cycle <= '0;
            for (int unsigned c = 0; c < NUM_CH; c++) r_shadow[c] <= '0;
        end else begin
            r_cycle <= r_cycle + CNT_W'(1);
            for (int unsigned c = 0; c < NUM_CH; c++) begin
                if (w_hit[c]) r_shadow[c] <= mem_wdata;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + PTR_W'(1);
            if (w_pop)  r_rd <= r_rd + PTR_W'(1);
            if (w_push && !w_pop)      r_count <= r_count + CNT_FW'(1);
            else if (w_pop && !w_push) r_count <= r_count - CNT_FW'(1);
        end
    end

    // Storage needs no reset: reads of stale slots are masked while empty.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fch[r_wr]   <= w_sel;
            r_fdata[r_wr] <= mem_wdata;
            r_fcyc[r_wr]  <= r_cycle;
        end
    end

    // A drop in the same cycle as a clear restarts the tally at one.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_overflow <= 1'b0;
            r_drop     <= '0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
            if (ovf_clr)               r_drop <= 16'd1;
            else if (r_drop != '1)     r_drop <= r_drop + 16'd1;
        end else if (ovf_clr) begin
            r_overflow <= 1'b0;
            r_drop     <= '0;
        end
    end

    assign evt_valid  = ~w_empty;
    assign evt_ch     = w_empty ? '0 : r_fch[r_rd];
    assign evt_data   = w_empty ? '0 : r_fdata[r_rd];
    assign evt_cycle  = w_empty ? '0 : r_fcyc[r_rd];
    assign fifo_count = r_count;
    assign cycle      = r_cycle;
    assign overflow   = r_overflow;
    assign drop_count = r_drop;

endmodule
